// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the single-cycle minisys CPU: generates the commit
// enable, stalls on switch reads, supports single-step and halts on syscall.
module cpu_run_ctrl #(
   parameter int          CNT_WIDTH = 32,
   parameter logic [31:0] HALT_INSN = 32'h0000_000C
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [31:0]          instruction,
   input  logic                 io_read,
   input  logic                 confirm,
   input  logic                 step_mode,
   output logic                 cpu_en,
   output logic                 io_latch,
   output logic [1:0]           state,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] cycle_cnt,
   output logic [CNT_WIDTH-1:0] retired_cnt
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      WAIT_IO   = 2'd1,
      STEP_WAIT = 2'd2,
      HALT      = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 w_halt_hit;
   logic                 w_cpu_en;
   logic [CNT_WIDTH-1:0] r_cycle_cnt;
   logic [CNT_WIDTH-1:0] r_retired_cnt;

   assign w_halt_hit = (instruction == HALT_INSN);

   // Mealy commit enable: the current instruction commits in the same cycle
   // the sequencer decides to let it through.
   always_comb begin
      w_cpu_en = 1'b0;
      w_next   = r_state;
      case (r_state)
         RUN: begin
            if (w_halt_hit)      w_next = HALT;
            else if (io_read)    w_next = WAIT_IO;
            else if (step_mode)  w_next = STEP_WAIT;
            else                 w_cpu_en = 1'b1;
         end
         WAIT_IO: begin
            if (confirm) begin
               w_cpu_en = 1'b1;
               w_next   = step_mode ? STEP_WAIT : RUN;
            end
         end
         STEP_WAIT: begin
            if (!step_mode) begin
               w_next = RUN;
            end else if (confirm) begin
               // A confirm that lands on a switch read only enters the stall;
               // the read itself waits for a fresh confirm.
               if (w_halt_hit)    w_next = HALT;
               else if (io_read)  w_next = WAIT_IO;
               else               w_cpu_en = 1'b1;
            end
         end
         HALT: begin
            w_next = HALT;
         end
         default: begin
            w_next = RUN;
         end
      endcase
      if (reset) begin
         w_cpu_en = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= RUN;
         r_cycle_cnt   <= '0;
         r_retired_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (r_state != HALT) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
         end
         if (w_cpu_en) begin
            r_retired_cnt <= r_retired_cnt + 1'b1;
         end
      end
   end

   assign cpu_en      = w_cpu_en;
   assign io_latch    = w_cpu_en & io_read;
   assign state       = r_state;
   assign halted      = (r_state == HALT);
   assign cycle_cnt   = r_cycle_cnt;
   assign retired_cnt = r_retired_cnt;

endmodule
